// File: rtl/huffman_pkg.sv
// huffman_pkg
//   Shared definitions for the Huffman code-building stage: FSM state
//   encoding, symbol/round constants, the default node-weight width and a
//   helper that turns a code length into a right-justified bit mask.
//   `HUFF_SYM_W gives the width of one per-symbol field in the packed
//   count/code/mask buses.
`ifndef HUFF_SYM_W
`define HUFF_SYM_W 8
`endif

package huffman_pkg;

  localparam int NSYM       = 6;            // symbols / tree slots
  localparam int ROUNDS     = 5;            // merges needed for NSYM leaves
  localparam int WW_DEFAULT = 11;           // holds 6 * 255 without overflow
  localparam int SYM_W      = `HUFF_SYM_W;  // per-symbol field width
  localparam int IDX_W      = 3;            // slot index width

  // Slot index meaning "nothing selected yet" in the min-pair scan.
  localparam logic [IDX_W-1:0] IDX_NONE = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FIND  = 3'd2,
    ST_MERGE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // (1 << len) - 1 : the code mask for a code of length len.
  function automatic logic [SYM_W-1:0] len_to_mask(input logic [2:0] len);
    return SYM_W'((1 << len) - 1);
  endfunction

endpackage

// File: rtl/huffman_min2_scan.sv
// huffman_min2_scan
//   Serial tracker of the two lightest valid slots. One (weight, valid,
//   index) triple is offered per step; slots must be offered in ascending
//   index order. Using <= in both comparisons makes a later (higher) slot
//   win a tie, so among equal weights the higher slot counts as smaller.
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   asynchronous, active-low reset
//   clear     in   restart the scan (both minima back to "none", max weight)
//   step      in   consider the slot presented on weight/valid/idx
//   weight    in   weight of the offered slot
//   valid     in   slot still holds a live node
//   idx       in   index of the offered slot
//   min1_idx  out  lightest slot seen since clear
//   min2_idx  out  second-lightest slot seen since clear
module huffman_min2_scan
  import huffman_pkg::*;
#(
  parameter int WW = WW_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             step,
  input  logic [WW-1:0]    weight,
  input  logic             valid,
  input  logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] min1_idx,
  output logic [IDX_W-1:0] min2_idx
);

  logic [WW-1:0]    min1_w_reg;
  logic [WW-1:0]    min2_w_reg;
  logic [IDX_W-1:0] min1_idx_reg;
  logic [IDX_W-1:0] min2_idx_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      min1_w_reg   <= '0;
      min2_w_reg   <= '0;
      min1_idx_reg <= '0;
      min2_idx_reg <= '0;
    end else if (clear) begin
      min1_w_reg   <= '1;
      min2_w_reg   <= '1;
      min1_idx_reg <= IDX_NONE;
      min2_idx_reg <= IDX_NONE;
    end else if (step && valid) begin
      if (weight <= min1_w_reg) begin
        min2_w_reg   <= min1_w_reg;
        min2_idx_reg <= min1_idx_reg;
        min1_w_reg   <= weight;
        min1_idx_reg <= idx;
      end else if (weight <= min2_w_reg) begin
        min2_w_reg   <= weight;
        min2_idx_reg <= idx;
      end
    end
  end

  assign min1_idx = min1_idx_reg;
  assign min2_idx = min2_idx_reg;

endmodule

// File: rtl/huffman_merge_ctrl.sv
// huffman_merge_ctrl
//   Huffman code builder for six symbols. After start it loads the six
//   counts as leaf nodes, then repeats FIND (6-cycle serial min-pair scan)
//   and MERGE (join the two lightest nodes, prepend one code bit to every
//   member symbol) until a single tree remains, and pulses code_valid.
//
//   Build option HUFF_ZERO_SKIP_EN: zero counts are excluded from the tree
//   (their code and mask are 0), the number of rounds becomes
//   (nonzero symbols - 1), and with at most one nonzero symbol the FSM goes
//   straight from LOAD to DONE. Without it, exactly five rounds are run and
//   zero counts are ordinary weight-0 leaves.
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   asynchronous, active-low reset
//   start       in   one-cycle pulse with valid counts, honoured only in IDLE
//   cnt_in      in   counts, symbol k (1..6) at [8k-1:8k-8]
//   busy        out  high from LOAD through DONE
//   code_valid  out  one-cycle pulse in DONE
//   hc_out      out  codes, symbol k at [8k-1:8k-8], right-justified
//   m_out       out  masks, symbol k at [8k-1:8k-8], (1<<len)-1
module huffman_merge_ctrl
  import huffman_pkg::*;
#(
  parameter int WW = WW_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NSYM*SYM_W-1:0] cnt_in,
  output logic                  busy,
  output logic                  code_valid,
  output logic [NSYM*SYM_W-1:0] hc_out,
  output logic [NSYM*SYM_W-1:0] m_out
);

  state_t                  state_reg;
  logic [IDX_W-1:0]        scan_idx_reg;
  logic [2:0]              round_reg;
  logic [NSYM*SYM_W-1:0]   cnt_reg;
  logic [WW-1:0]           weight_reg [NSYM];
  logic [NSYM-1:0]         valid_reg;
  logic [NSYM-1:0]         mask_reg   [NSYM];
  logic [SYM_W-1:0]        hc_reg     [NSYM];
  logic [2:0]              len_reg    [NSYM];
  logic [NSYM*SYM_W-1:0]   hc_out_reg;
  logic [NSYM*SYM_W-1:0]   m_out_reg;
  logic                    busy_reg;
  logic                    code_valid_reg;

  logic [IDX_W-1:0]        min1_idx;
  logic [IDX_W-1:0]        min2_idx;
  logic [SYM_W-1:0]        hc_mrg     [NSYM];
  logic [2:0]              len_mrg    [NSYM];
  logic [NSYM*SYM_W-1:0]   hc_mrg_flat;
  logic [NSYM*SYM_W-1:0]   m_mrg_flat;
  logic [2:0]              last_round;

  // The scanner restarts in LOAD and MERGE so every FIND begins fresh.
  huffman_min2_scan #(
    .WW (WW)
  ) u_scan (
    .clk      (clk),
    .reset    (reset),
    .clear    ((state_reg == ST_LOAD) || (state_reg == ST_MERGE)),
    .step     (state_reg == ST_FIND),
    .weight   (weight_reg[scan_idx_reg]),
    .valid    (valid_reg[scan_idx_reg]),
    .idx      (scan_idx_reg),
    .min1_idx (min1_idx),
    .min2_idx (min2_idx)
  );

  // Code state each symbol would have after merging min1 (bit 1) into
  // min2 (bit 0). Only committed in MERGE.
  genvar gi;
  generate
    for (gi = 0; gi < NSYM; gi++) begin : g_sym
      logic in_min1;
      logic in_min2;
      assign in_min1 = mask_reg[min1_idx][gi];
      assign in_min2 = mask_reg[min2_idx][gi];

      assign hc_mrg[gi]  = in_min1 ? (hc_reg[gi] | (SYM_W'(1) << len_reg[gi]))
                                   : hc_reg[gi];
      assign len_mrg[gi] = (in_min1 || in_min2) ? len_reg[gi] + 3'd1
                                                : len_reg[gi];

      assign hc_mrg_flat[gi*SYM_W +: SYM_W] = hc_mrg[gi];
      assign m_mrg_flat[gi*SYM_W +: SYM_W]  = len_to_mask(len_mrg[gi]);
    end
  endgenerate

`ifdef HUFF_ZERO_SKIP_EN
  logic [NSYM-1:0]       nz;
  logic [2:0]            nz_cnt;
  logic [2:0]            last_round_reg;
  logic [NSYM*SYM_W-1:0] m_load_flat;

  generate
    for (gi = 0; gi < NSYM; gi++) begin : g_nz
      assign nz[gi] = |cnt_reg[gi*SYM_W +: SYM_W];
      // A lone nonzero symbol gets the 1-bit code "0".
      assign m_load_flat[gi*SYM_W +: SYM_W] = {{(SYM_W-1){1'b0}}, nz[gi]};
    end
  endgenerate

  always_comb begin
    nz_cnt = '0;
    for (int i = 0; i < NSYM; i++) begin
      nz_cnt = nz_cnt + {2'b00, nz[i]};
    end
  end

  assign last_round = last_round_reg;
`else
  assign last_round = 3'(ROUNDS - 1);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      scan_idx_reg   <= '0;
      round_reg      <= '0;
      cnt_reg        <= '0;
      valid_reg      <= '0;
      hc_out_reg     <= '0;
      m_out_reg      <= '0;
      busy_reg       <= 1'b0;
      code_valid_reg <= 1'b0;
      for (int i = 0; i < NSYM; i++) begin
        weight_reg[i] <= '0;
        mask_reg[i]   <= '0;
        hc_reg[i]     <= '0;
        len_reg[i]    <= '0;
      end
`ifdef HUFF_ZERO_SKIP_EN
      last_round_reg <= '0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            cnt_reg   <= cnt_in;
            busy_reg  <= 1'b1;
            state_reg <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          for (int i = 0; i < NSYM; i++) begin
            weight_reg[i] <= WW'(cnt_reg[i*SYM_W +: SYM_W]);
            mask_reg[i]   <= NSYM'(1) << i;
            hc_reg[i]     <= '0;
            len_reg[i]    <= '0;
          end
          round_reg    <= '0;
          scan_idx_reg <= '0;
          hc_out_reg   <= '0;
          m_out_reg    <= '0;
`ifdef HUFF_ZERO_SKIP_EN
          valid_reg <= nz;
          if (nz_cnt <= 3'd1) begin
            m_out_reg      <= m_load_flat;
            code_valid_reg <= 1'b1;
            state_reg      <= ST_DONE;
          end else begin
            last_round_reg <= nz_cnt - 3'd2;
            state_reg      <= ST_FIND;
          end
`else
          valid_reg <= '1;
          state_reg <= ST_FIND;
`endif
        end

        ST_FIND: begin
          if (scan_idx_reg == IDX_W'(NSYM - 1)) begin
            scan_idx_reg <= '0;
            state_reg    <= ST_MERGE;
          end else begin
            scan_idx_reg <= scan_idx_reg + IDX_W'(1);
          end
        end

        ST_MERGE: begin
          for (int i = 0; i < NSYM; i++) begin
            hc_reg[i]  <= hc_mrg[i];
            len_reg[i] <= len_mrg[i];
          end
          weight_reg[min2_idx] <= weight_reg[min2_idx] + weight_reg[min1_idx];
          mask_reg[min2_idx]   <= mask_reg[min2_idx] | mask_reg[min1_idx];
          valid_reg[min1_idx]  <= 1'b0;
          round_reg            <= round_reg + 3'd1;
          if (round_reg == last_round) begin
            // Publish the post-merge codes so they line up with code_valid.
            hc_out_reg     <= hc_mrg_flat;
            m_out_reg      <= m_mrg_flat;
            code_valid_reg <= 1'b1;
            state_reg      <= ST_DONE;
          end else begin
            state_reg <= ST_FIND;
          end
        end

        ST_DONE: begin
          code_valid_reg <= 1'b0;
          busy_reg       <= 1'b0;
          state_reg      <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_reg;
  assign code_valid = code_valid_reg;
  assign hc_out     = hc_out_reg;
  assign m_out      = m_out_reg;

endmodule

// File: tb/tb_huffman_merge_ctrl.sv
// tb_huffman_merge_ctrl
//   Self-checking bench for huffman_merge_ctrl: directed vectors, extra
//   start pulses, a mid-run reset and randomized counts compared with a
//   reference model that builds the tree from a sorted node list.
module tb_huffman_merge_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [47:0] cnt_in = '0;
  logic        busy;
  logic        code_valid;
  logic [47:0] hc_out;
  logic [47:0] m_out;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [47:0] CNT_DESC = 48'h01_02_04_08_10_20;
  localparam logic [47:0] HC_DESC  = 48'h1F_1E_0E_06_02_00;
  localparam logic [47:0] M_DESC   = 48'h1F_1F_0F_07_03_01;
  localparam logic [47:0] CNT_TIE  = 48'h0A_0A_0A_0A_0A_0A;
  localparam logic [47:0] HC_TIE   = 48'h03_02_01_00_03_02;
  localparam logic [47:0] M_TIE    = 48'h07_07_07_07_03_03;

  huffman_merge_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cnt_in     (cnt_in),
    .busy       (busy),
    .code_valid (code_valid),
    .hc_out     (hc_out),
    .m_out      (m_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: each round sorts the live nodes by (weight ascending,
  // slot descending), merges the first (bit 1) into the second (bit 0).
  function automatic void ref_model(input logic [47:0] cnt, output logic [47:0] hc,
                                    output logic [47:0] m, output int lat);
    int       w    [6];
    bit       alive[6];
    bit [5:0] grp  [6];
    int       code [6];
    int       len  [6];
    int       keys [$];
    int       rounds;
    int       a;
    int       b;
`ifdef HUFF_ZERO_SKIP_EN
    int       n_alive = 0;
`endif
    for (int s = 0; s < 6; s++) begin
      w[s]    = int'(cnt[s*8 +: 8]);
      grp[s]  = 6'(1) << s;
      code[s] = 0;
      len[s]  = 0;
`ifdef HUFF_ZERO_SKIP_EN
      alive[s] = (w[s] != 0);
      if (alive[s]) n_alive++;
`else
      alive[s] = 1'b1;
`endif
    end
`ifdef HUFF_ZERO_SKIP_EN
    rounds = (n_alive > 1) ? n_alive - 1 : 0;
    if (n_alive == 1) begin
      for (int s = 0; s < 6; s++) if (alive[s]) len[s] = 1;
    end
`else
    rounds = 5;
`endif
    for (int r = 0; r < rounds; r++) begin
      keys.delete();
      for (int s = 0; s < 6; s++) if (alive[s]) keys.push_back(w[s] * 8 + (7 - s));
      keys.sort();
      a = 7 - (keys[0] % 8);
      b = 7 - (keys[1] % 8);
      for (int s = 0; s < 6; s++) begin
        if (grp[a][s]) begin
          code[s] += (1 << len[s]);
          len[s]++;
        end else if (grp[b][s]) begin
          len[s]++;
        end
      end
      w[b]     += w[a];
      grp[b]   |= grp[a];
      alive[a]  = 1'b0;
    end
    hc = '0;
    m  = '0;
    for (int s = 0; s < 6; s++) begin
      hc[s*8 +: 8] = 8'(code[s]);
      m[s*8 +: 8]  = 8'((1 << len[s]) - 1);
    end
    lat = 2 + 7 * rounds;
  endfunction

  // One job: pulse start, then check busy/code_valid every cycle against
  // the model latency, capture the codes on code_valid and compare.
  task automatic do_run(input string name, input logic [47:0] cnt, input bit extra_starts,
                        output logic [47:0] got_hc, output logic [47:0] got_m);
    logic [47:0] exp_hc;
    logic [47:0] exp_m;
    logic [63:0] junk;
    int          exp_lat;
    int          seen;
    ref_model(cnt, exp_hc, exp_m, exp_lat);
    got_hc = '0;
    got_m  = '0;
    seen   = 0;
    @(negedge clk);
    cnt_in = cnt;
    start  = 1'b1;
    for (int c = 1; c <= exp_lat + 6; c++) begin
      @(negedge clk);
      start  = 1'b0;
      junk   = {$urandom, $urandom};
      cnt_in = junk[47:0];
      check({name, "/busy"}, 64'(busy), 64'(c <= exp_lat));
      check({name, "/code_valid"}, 64'(code_valid), 64'(c == exp_lat));
      if (code_valid) begin
        seen++;
        got_hc = hc_out;
        got_m  = m_out;
      end
      if (extra_starts && c <= exp_lat && (c == 3 || c == 20 || c == exp_lat)) start = 1'b1;
    end
    check({name, "/pulses"}, 64'(seen), 64'd1);
    check({name, "/hc"}, 64'(got_hc), 64'(exp_hc));
    check({name, "/m"}, 64'(got_m), 64'(exp_m));
    check({name, "/hc_hold"}, 64'(hc_out), 64'(exp_hc));
    $display("run %s cnt=%012h hc=%012h m=%012h lat=%0d", name, cnt, got_hc, got_m, exp_lat);
  endtask

  initial begin
    logic [47:0] hc;
    logic [47:0] m;
    logic [47:0] cnt;
    int          pulses;

    repeat (3) @(negedge clk);
    check("rst/busy", 64'(busy), 64'd0);
    check("rst/code_valid", 64'(code_valid), 64'd0);
    check("rst/hc_out", 64'(hc_out), 64'd0);
    check("rst/m_out", 64'(m_out), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    do_run("descend", CNT_DESC, 1'b0, hc, m);
    check("descend/hc_const", 64'(hc), 64'(HC_DESC));
    check("descend/m_const", 64'(m), 64'(M_DESC));

    do_run("ties", CNT_TIE, 1'b0, hc, m);
    check("ties/hc_const", 64'(hc), 64'(HC_TIE));
    check("ties/m_const", 64'(m), 64'(M_TIE));

    do_run("extra_start", CNT_DESC, 1'b1, hc, m);
    check("extra_start/hc_const", 64'(hc), 64'(HC_DESC));
    check("extra_start/m_const", 64'(m), 64'(M_DESC));

    // Reset in cycle 20 of a run: everything clears, no code_valid follows.
    @(negedge clk);
    cnt_in = CNT_TIE;
    start  = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b0;
    #1;
    check("midrst/busy", 64'(busy), 64'd0);
    check("midrst/code_valid", 64'(code_valid), 64'd0);
    check("midrst/hc_out", 64'(hc_out), 64'd0);
    check("midrst/m_out", 64'(m_out), 64'd0);
    @(negedge clk);
    reset  = 1'b1;
    pulses = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (code_valid || busy) pulses++;
    end
    check("midrst/quiet", 64'(pulses), 64'd0);
    $display("run midrst aborted at cycle 20");
    do_run("after_rst", CNT_DESC, 1'b0, hc, m);
    check("after_rst/hc_const", 64'(hc), 64'(HC_DESC));
    check("after_rst/m_const", 64'(m), 64'(M_DESC));

`ifdef HUFF_ZERO_SKIP_EN
    do_run("zskip", 48'h00_03_00_05_00_00, 1'b0, hc, m);
    check("zskip/hc_const", 64'(hc), 64'h00_01_00_00_00_00);
    check("zskip/m_const", 64'(m), 64'h00_01_00_01_00_00);
`endif

    do_run("all_zero", 48'h0, 1'b0, hc, m);
    do_run("one_nz", 48'h00_00_2A_00_00_00, 1'b0, hc, m);

    for (int r = 0; r < 24; r++) begin
      for (int s = 0; s < 6; s++) begin
        case (r % 3)
          0:       cnt[s*8 +: 8] = 8'($urandom_range(0, 255));
          1:       cnt[s*8 +: 8] = 8'($urandom_range(0, 3));
          default: cnt[s*8 +: 8] = 8'($urandom_range(1, 40));
        endcase
      end
      do_run($sformatf("rand%0d", r), cnt, 1'b0, hc, m);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
